// File: rtl/shared_counter_sched.sv
`default_nettype none
// ============================================================================
// Module      : shared_counter_sched
// Description : Round-robin time-sharing of one CW-bit up counter between
//               NREQ interval requesters. The granted requester's terminal
//               count is latched at grant; the counter runs 0..tc and then
//               a one-cycle done pulse reports the completed requester.
// Revision    : 1.0 - initial release
// ============================================================================
module shared_counter_sched #(
    parameter int  NREQ = 4,
    parameter int  CW   = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] tc,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [CW-1:0]     cnt,
    output logic              done,
    output logic [IW-1:0]     done_id
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [NREQ-1:0] c_one = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic [IW-1:0]   r_done_id;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_win;
    logic [CW-1:0]   r_tc_lat;

    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [CW-1:0]   w_tc_sel;
    logic [NREQ-1:0] w_onehot;

    // Round-robin search: first set request starting one above the last owner
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(r_rr) + i) % NREQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = IW'(idx);
            end
        end
    end

    assign w_tc_sel = tc[w_win*CW +: CW];
    assign w_onehot = c_one << w_win;

    // Grant / count / done sequencer; tc is captured only at grant time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_rr      <= IW'(NREQ - 1);
            r_win     <= '0;
            r_tc_lat  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_cnt  <= '0;
                    if (w_found) begin
                        r_state  <= S_RUN;
                        r_gnt    <= w_onehot;
                        r_win    <= w_win;
                        r_tc_lat <= w_tc_sel;
                    end
                end
                S_RUN: begin
                    if (!req[r_win]) begin
                        // Owner withdrew: release without reporting completion
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                        r_rr    <= r_win;
                    end else if (r_cnt == r_tc_lat) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_done_id <= r_win;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                    r_rr    <= r_win;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign cnt     = r_cnt;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign busy    = (r_state == S_RUN) || (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shared_counter_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_counter_sched
// Description : Directed bench for shared_counter_sched. Stimulus pushes the
//               expected (requester, final count) of each completed interval;
//               a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_counter_sched;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int IW   = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*CW-1:0] tc;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [CW-1:0]     cnt;
    logic              done;
    logic [IW-1:0]     done_id;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    bit prev_done = 1'b0;

    int exp_id[$];
    int exp_cnt[$];

    shared_counter_sched #(.NREQ(NREQ), .CW(CW)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .tc      (tc),
        .gnt     (gnt),
        .busy    (busy),
        .cnt     (cnt),
        .done    (done),
        .done_id (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                chk("post_done_gnt", 32'(gnt), 0);
                chk("post_done_cnt", 32'(cnt), 0);
                chk("post_done_busy", 32'(busy), 0);
            end
            if (done) begin
                if (exp_id.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done_id=%0d cnt=%0d, expected no done", done_id, cnt);
                end else begin
                    int id;
                    int c;
                    id = exp_id.pop_front();
                    c  = exp_cnt.pop_front();
                    chk("done_id", 32'(done_id), 32'(id));
                    chk("done_cnt", 32'(cnt), 32'(c));
                    chk("done_gnt", 32'(gnt), 32'(1) << id);
                    chk("done_busy", 32'(busy), 1);
                end
                n_done++;
            end
            prev_done = done;
        end
    end

    task automatic set_tc(input int id, input int v);
        tc[id*CW +: CW] = CW'(v);
    endtask

    // Wait (bounded) until the monitor has seen target done pulses
    task automatic wait_done(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (n_done < target) chk({name, "_timeout"}, 32'(n_done), 32'(target));
    endtask

    // Single request; checks done latency of tc+2 cycles from the request edge
    task automatic run_one(input int id, input int tcv, input int tc_new, input int exp_c);
        int k;
        set_tc(id, tcv);
        req = NREQ'(1) << id;
        exp_id.push_back(id);
        exp_cnt.push_back(exp_c);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            #2;
            k++;
            if (k == 1) set_tc(id, tc_new);
            if (done) break;
        end
        chk("run_latency", 32'(k), 32'(exp_c + 2));
        req = '0;
        @(negedge clk);
        #2;
    endtask

    initial begin
        int k;
        rst = 1'b0;
        req = '0;
        tc  = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(cnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-interval aborts immediately with no done
        set_tc(0, 9);
        req = 4'b0001;
        k = 0;
        while (cnt != 4'd5 && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("t1_reach_cnt5", 32'(cnt), 5);
        rst = 1'b0;
        #1;
        chk("t1_gnt", 32'(gnt), 0);
        chk("t1_cnt", 32'(cnt), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_done", 32'(done), 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Round-robin from reset with all requests held and tc=0
        tc = '0;
        foreach (exp_id[i]) ;
        exp_id.push_back(0); exp_cnt.push_back(0);
        exp_id.push_back(1); exp_cnt.push_back(0);
        exp_id.push_back(2); exp_cnt.push_back(0);
        exp_id.push_back(3); exp_cnt.push_back(0);
        exp_id.push_back(0); exp_cnt.push_back(0);
        req = 4'b1111;
        wait_done(n_done + 5, 40, "t3");
        req = '0;
        repeat (2) @(negedge clk);

        // Single request tc=3 with per-cycle timing
        set_tc(0, 3);
        req = 4'b0001;
        exp_id.push_back(0);
        exp_cnt.push_back(3);
        @(negedge clk);
        chk("t2_gnt", 32'(gnt), 1);
        chk("t2_cnt0", 32'(cnt), 0);
        chk("t2_busy", 32'(busy), 1);
        @(negedge clk); chk("t2_cnt1", 32'(cnt), 1);
        @(negedge clk); chk("t2_cnt2", 32'(cnt), 2);
        @(negedge clk); chk("t2_cnt3", 32'(cnt), 3);
        chk("t2_no_early_done", 32'(done), 0);
        @(negedge clk);
        #2;
        chk("t2_done", 32'(done), 1);
        req = '0;
        @(negedge clk);
        chk("t2_gnt_low", 32'(gnt), 0);
        @(negedge clk);

        // Abort by dropping req[2] at cnt=4, then re-arbitrate from rr=2
        set_tc(2, 9);
        set_tc(0, 1);
        req = 4'b0100;
        k = 0;
        while (cnt != 4'd4 && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("t4_gnt", 32'(gnt), 32'b0100);
        chk("t4_reach_cnt4", 32'(cnt), 4);
        req = 4'b0000;
        @(negedge clk);
        chk("t4_abort_gnt", 32'(gnt), 0);
        chk("t4_abort_cnt", 32'(cnt), 0);
        chk("t4_abort_busy", 32'(busy), 0);
        chk("t4_abort_done", 32'(done), 0);
        #2;
        req = 4'b0101;
        exp_id.push_back(0);
        exp_cnt.push_back(1);
        @(negedge clk);
        chk("t4_regrant", 32'(gnt), 32'b0001);
        wait_done(n_done + 1, 20, "t4");
        req = '0;
        repeat (2) @(negedge clk);
        #2;

        // Boundaries: maximum and zero terminal counts
        run_one(3, 15, 15, 15);
        run_one(2, 0, 0, 0);

        // tc changes after grant are ignored
        run_one(1, 2, 7, 2);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(exp_id.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
